// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the architectural PC constants used across the pipeline.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam logic [31:0] PC_INITIAL_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] ERROR_ENTRY         = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE_DEFAULT  = 32'h0000_7CB0;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] v;
        v = '0;
        v[SR_IM_HI:SR_IM_LO] = im;
        v[SR_EXL] = exl;
        v[SR_IE] = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v = '0;
        v[CAUSE_BD] = bd;
        v[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
        v[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_unit_req_gen.sv
// Combinational interrupt/exception request decision; interrupts win over
// exceptions and nothing is requested while EXL is set.
module cp0_req_gen
    import cp0_unit_pkg::*;
(
    input  logic [5:0] i_hwint,
    input  logic [5:0] i_sr_im,
    input  logic       i_sr_ie,
    input  logic       i_sr_exl,
    input  logic [4:0] i_exc_code,
    output logic       o_int_req,
    output logic       o_exc_req,
    output logic       o_req
);

    assign o_int_req = (|(i_hwint & i_sr_im)) & i_sr_ie & ~i_sr_exl;
    assign o_exc_req = (i_exc_code != EXC_INT) & ~i_sr_exl;
    assign o_req     = o_int_req | o_exc_req;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PRId, exception entry, eret
// and mtc0 handling, plus the pipeline-wide flush request.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = PRID_VALUE_DEFAULT,
    parameter logic [31:0] PC_INITIAL = PC_INITIAL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  M_ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        M_mtc0,
    input  logic        M_eret,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic [31:0] EPC_out,
    output logic        req
);

    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_epc_src;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused;

    cp0_req_gen u_req_gen (
        .i_hwint    (HWInt),
        .i_sr_im    (r_sr_im),
        .i_sr_ie    (r_sr_ie),
        .i_sr_exl   (r_sr_exl),
        .i_exc_code (M_ExcCode),
        .o_int_req  (w_int_req),
        .o_exc_req  (w_exc_req),
        .o_req      (w_req)
    );

    // A delay-slot victim restarts at its branch so the branch is re-executed.
    assign w_epc_src = M_BD ? (M_PC - 32'd4) : M_PC;

    assign w_sr    = pack_sr(r_sr_im, r_sr_exl, r_sr_ie);
    assign w_cause = pack_cause(r_cause_bd, r_cause_ip, r_cause_exc);

    assign w_unused = ^{w_epc_src[1:0], w_exc_req, cp0_wdata[31:16], cp0_wdata[9:2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= PC_INITIAL;
        end else begin
            r_cause_ip <= HWInt;
            if (w_req) begin
                // The victimised instruction's own mtc0/eret effects are dropped.
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= M_BD;
                r_cause_exc <= w_int_req ? EXC_INT : M_ExcCode;
                r_epc       <= {w_epc_src[31:2], 2'b00};
            end else begin
                if (M_eret) begin
                    r_sr_exl <= 1'b0;
                end
                if (M_mtc0) begin
                    case (cp0_addr)
                        CP0_SR: begin
                            r_sr_im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                            r_sr_exl <= cp0_wdata[SR_EXL];
                            r_sr_ie  <= cp0_wdata[SR_IE];
                        end
                        CP0_EPC: r_epc <= {cp0_wdata[31:2], 2'b00};
                        default: ;
                    endcase
                end
            end
        end
    end

    // Reads return pre-write values; M->W forwarding covers a following mfc0.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = w_sr;
            CP0_CAUSE: cp0_rdata = w_cause;
            CP0_EPC:   cp0_rdata = r_epc;
            CP0_PRID:  cp0_rdata = PRID_VALUE;
            default:   cp0_rdata = '0;
        endcase
    end

    assign EPC_out = r_epc;
    assign req     = w_req;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset values, interrupt/exception entry,
// EXL masking, eret re-arm, mtc0 victimisation and interrupt priority.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_PC;
    logic        M_BD;
    logic [4:0]  M_ExcCode;
    logic [5:0]  HWInt;
    logic        M_mtc0;
    logic        M_eret;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] EPC_out;
    logic        req;

    int checks = 0;
    int errors = 0;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .M_PC      (M_PC),
        .M_BD      (M_BD),
        .M_ExcCode (M_ExcCode),
        .HWInt     (HWInt),
        .M_mtc0    (M_mtc0),
        .M_eret    (M_eret),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .EPC_out   (EPC_out),
        .req       (req)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        cp0_addr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    task automatic chk_req(input logic exp, input string tag);
        #1;
        chk(tag, {31'b0, req}, {31'b0, exp});
    endtask

    initial begin
        reset = 1'b1; M_PC = 32'h3000; M_BD = 1'b0; M_ExcCode = 5'd0; HWInt = 6'd0;
        M_mtc0 = 1'b0; M_eret = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        rd(5'd12, 32'h0000_0000, "rst_sr");
        rd(5'd13, 32'h0000_0000, "rst_cause");
        rd(5'd14, 32'h0000_3000, "rst_epc");
        rd(5'd15, 32'h0000_7CB0, "rst_prid");
        rd(5'd3,  32'h0000_0000, "rst_other_addr");
        chk("rst_epc_out", EPC_out, 32'h0000_3000);
        chk_req(1'b0, "rst_req");

        // mtc0 SR = FC01; read in the same cycle still shows the old value
        M_mtc0 = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01; M_PC = 32'h300C;
        #1;
        chk("mtc0_sr_pre_read", cp0_rdata, 32'h0000_0000);
        chk_req(1'b0, "mtc0_sr_req");
        tick();
        M_mtc0 = 1'b0; HWInt = 6'b000001; M_PC = 32'h3010;
        chk_req(1'b1, "int_req");
        tick();
        rd(5'd13, 32'h0000_0400, "int_cause");
        rd(5'd12, 32'h0000_FC03, "int_sr_exl");
        chk("int_epc", EPC_out, 32'h0000_3010);
        chk_req(1'b0, "int_held_exl_masks");

        // Reprogram SR: IM all, IE=0, EXL=0; then RI in a delay slot
        HWInt = 6'd0;
        M_mtc0 = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC00;
        tick();
        M_mtc0 = 1'b0; M_ExcCode = 5'd10; M_BD = 1'b1; M_PC = 32'h3024;
        chk_req(1'b1, "ri_req");
        tick();
        M_ExcCode = 5'd0; M_BD = 1'b0;
        rd(5'd13, 32'h8000_0028, "ri_cause");
        chk("ri_epc", EPC_out, 32'h0000_3020);
        rd(5'd12, 32'h0000_FC02, "ri_sr");

        // Ov while EXL=1 is ignored
        M_ExcCode = 5'd12; M_PC = 32'h3030;
        chk_req(1'b0, "ov_exl_req");
        tick();
        M_ExcCode = 5'd0;
        rd(5'd13, 32'h8000_0028, "ov_exl_cause");
        chk("ov_exl_epc", EPC_out, 32'h0000_3020);

        // Enable IE while still in the handler, raise HWInt[2], then eret
        M_mtc0 = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC03; HWInt = 6'b000100;
        chk_req(1'b0, "ie_set_exl_req");
        tick();
        M_mtc0 = 1'b0; M_eret = 1'b1;
        chk_req(1'b0, "eret_req");
        tick();
        M_eret = 1'b0;
        rd(5'd12, 32'h0000_FC01, "eret_sr");
        rd(5'd13, 32'h8000_1028, "eret_cause_ip");

        // Interrupt after eret; a same-cycle mtc0 to EPC is victimised
        M_PC = 32'h3038; M_BD = 1'b0;
        M_mtc0 = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3047;
        chk_req(1'b1, "post_eret_int_req");
        tick();
        M_mtc0 = 1'b0;
        chk("victim_mtc0_epc", EPC_out, 32'h0000_3038);
        rd(5'd13, 32'h0000_1000, "post_eret_cause");

        // mtc0 EPC without req: low bits forced to zero
        M_mtc0 = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3047;
        tick();
        M_mtc0 = 1'b0;
        chk("mtc0_epc", EPC_out, 32'h0000_3044);

        // Cause and PRId are not writable
        M_mtc0 = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
        tick();
        cp0_addr = 5'd15;
        tick();
        M_mtc0 = 1'b0;
        rd(5'd13, 32'h0000_1000, "cause_ro");
        rd(5'd15, 32'h0000_7CB0, "prid_ro");
        rd(5'd12, 32'h0000_FC03, "sr_after_ro");

        // eret, then interrupt and AdEL together: interrupt wins
        M_eret = 1'b1; HWInt = 6'd0;
        tick();
        M_eret = 1'b0; HWInt = 6'b000001; M_ExcCode = 5'd4; M_PC = 32'h3050;
        chk_req(1'b1, "prio_req");
        tick();
        M_ExcCode = 5'd0;
        rd(5'd13, 32'h0000_0400, "prio_cause");
        chk("prio_epc", EPC_out, 32'h0000_3050);

        // Reset mid-handler clears everything
        reset = 1'b1;
        tick();
        rd(5'd12, 32'h0000_0000, "midrst_sr");
        rd(5'd13, 32'h0000_0000, "midrst_cause");
        chk("midrst_epc", EPC_out, 32'h0000_3000);
        chk_req(1'b0, "midrst_req");
        reset = 1'b0; HWInt = 6'd0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor 0 for the P7 five-stage MIPS pipeline; sits at the M stage.
- Consumes per-instruction exception info carried down by the pipeline registers (ExcCode, BD, PC, mtc0/eret flags) plus external hardware interrupts.
- Produces the req flush that every pipeline register (D/E, E/M, M/W) obeys, and the EPC used by eret.
- Holds SR, Cause, EPC and PRId; it is the responder end of the pipeline-register exception interface.

Parameters:
- PRID_VALUE, 32'h0000_7CB0, constant read value of PRId (reg 15).
- PC_INITIAL, 32'h0000_3000, lowest legal PC; EPC reset value.

Ports:
- clk  in  1  clock clk
- reset  in  1  reset reset, synchronous, active-high
- M_PC  in  32  PC of the M-stage instruction; valid for bubbles inserted by clr (they keep D_PC/BD)
- M_BD  in  1  M-stage instruction is in a branch delay slot
- M_ExcCode  in  5  pending exception code from earlier stages; 0 = none
- HWInt  in  6  external interrupt lines (timer0, timer1, interrupt generator, 3 spare)
- M_mtc0  in  1  M-stage instruction is mtc0
- M_eret  in  1  M-stage instruction is eret
- cp0_addr  in  5  rd field of mfc0/mtc0
- cp0_wdata  in  32  mtc0 write data (forwarded rt)
- cp0_rdata  out  32  combinational read of register cp0_addr
- EPC_out  out  32  current EPC register
- req  out  1  exception/interrupt taken this cycle; combinational

Behaviour:
- Fields:
  - SR: IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
  - EPC: 32 bits.
  - PRId = PRID_VALUE, read-only.
- Combinational request logic:
  - IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL
  - ExcReq = (M_ExcCode != 0) & ~SR.EXL
  - req = IntReq | ExcReq
  - Interrupt has priority over exception.
- Reset: SR=0, Cause=0, EPC=PC_INITIAL. Hence req=0, cp0_rdata follows reset registers, EPC_out=PC_INITIAL.
- Every cycle, not in reset: Cause.IP <= HWInt, unconditionally, including the req cycle.
- Cycle with req=1, at the next edge:
  - SR.EXL <= 1
  - Cause.BD <= M_BD
  - Cause.ExcCode <= IntReq ? 0 : M_ExcCode
  - EPC <= M_BD ? M_PC-4 : M_PC, bits [1:0] forced 0
  - mtc0 and eret in the same cycle are suppressed; the instruction is victimised.
- eret with req=0: SR.EXL <= 0 at the edge. Pipeline redirect to EPC_out is handled elsewhere. eret never asserts req.
- mtc0 with req=0:
  - addr 12 writes SR bits [15:10],[1],[0].
  - addr 14 writes EPC with bits [1:0] forced 0.
  - addr 13 and 15 are ignored (Cause software-read-only here).
  - Other addresses: no effect.
- Read (cp0_rdata):
  - addr 12/13/14/15 returns the register value before this cycle's write; no internal bypass, since M→W forwarding covers mfc0.
  - Other addresses read 0.
- Latency: req is same-cycle. Register updates are visible the next cycle.
- Edge cases:
  - HWInt held while EXL=1: no req. IP still tracks HWInt.
  - EXL cleared by eret: a still-asserted interrupt raises req the following cycle.
  - M_ExcCode nonzero while EXL=1: ignored.
  - Reset mid-handler: EXL returns to 0 and all state is cleared.
- Constants: Error_Entry 32'h0000_4180 is consumed by pipeline registers and NPC, not by this block.

Decomposition:
- Shared macro header gets:
  - CP0 register numbers 12/13/14/15
  - SR/Cause field bit positions
  - ExcCode values: Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12
  - PC_Initial and Error_Entry
- One small sub-module, cp0_req_gen, is natural: purely combinational IntReq/ExcReq/req.

Test Plan:
- Reset, then read addr 12/13/14/15 → 0, 0, 32'h3000, PRID_VALUE; req=0.
- mtc0 SR=32'h0000_FC01, HWInt=6'b000001 next cycle → req=1 that cycle. Next cycle: Cause.ExcCode=0, Cause.IP=1, SR.EXL=1, EPC=M_PC (e.g. 32'h3010).
- M_ExcCode=10 (RI), M_BD=1, M_PC=32'h3024, SR.IE=0 → req=1. Then EPC=32'h3020, Cause=32'h8000_0028.
- EXL=1, M_ExcCode=12 → req=0, no state change. Then eret → EXL=0; with HWInt[2] and IM[12] set, req=1 the following cycle.
- mtc0 to EPC (wdata 32'h3047) in the same cycle as req=1 → EPC=exception PC, not 32'h3044. mtc0 to EPC with req=0 → EPC=32'h3044.
- Simultaneous HWInt (enabled) and M_ExcCode=4 → Cause.ExcCode=0 (interrupt priority); EPC=M_PC.
